// File: rtl/sc_mac_pkg.sv
// Shared types and default widths for the stochastic-computing MAC sequencer.
package sc_mac_pkg;

  localparam int LEN_W_DEF  = 8;
  localparam int TERM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sc_len_counter.sv
// Loadable down-counter for the bitstream length; zero_o flags the enabled
// decrement that brings the count to zero, i.e. the last bit of a stream.
module sc_len_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] len_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (en_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A loaded value of 0 stands for 2^W, so it is never taken as the last bit.
  assign zero_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/sc_mac_sequencer.sv
// Control sequencer for a stochastic-computing MAC: per product term, reload the
// SNG seeds for one cycle, then stream L bits into the accumulator; K terms per command.
module sc_mac_sequencer
  import sc_mac_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int TERM_W = TERM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [TERM_W-1:0] cmd_terms,
  input  logic              abort,
  output logic              sng_load,
  output logic              stream_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [TERM_W-1:0] term_idx,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TERM_W-1:0] terms_q, terms_d;
  logic [TERM_W-1:0] term_idx_q, term_idx_d;
  logic              run_last;

  sc_len_counter #(
    .W(LEN_W)
  ) u_len_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == ST_LOAD),
    .en_i   (state_q == ST_RUN),
    .len_i  (len_q),
    .zero_o (run_last)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    terms_d    = terms_q;
    term_idx_d = term_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          terms_d    = cmd_terms;
          term_idx_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // terms_q of 0 means 2^TERM_W terms; the modulo subtraction yields the all-ones last index.
        if (run_last) begin
          if (term_idx_q == terms_q - TERM_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            term_idx_d = term_idx_q + TERM_W'(1);
            state_d    = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      term_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      terms_q    <= '0;
      term_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      terms_q    <= terms_d;
      term_idx_q <= term_idx_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sng_load  = (state_q == ST_LOAD);
  assign acc_clr   = (state_q == ST_LOAD) && (term_idx_q == '0);
  assign stream_en = (state_q == ST_RUN);
  assign acc_en    = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign term_idx  = term_idx_q;

endmodule

// File: tb/tb_sc_mac_sequencer.sv
// Scoreboard bench for sc_mac_sequencer: expectations queued at issue, compared
// against per-command observations gathered by a negedge monitor.
module tb_sc_mac_sequencer;

  localparam int LEN_W  = 8;
  localparam int TERM_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [TERM_W-1:0] cmd_terms = '0;
  logic              abort = 1'b0;
  logic              sng_load, stream_en, acc_clr, acc_en;
  logic [TERM_W-1:0] term_idx;
  logic              busy, out_valid;
  logic              out_ready = 1'b1;

  typedef struct {
    int lat;
    int sng;
    int clr;
    int str;
  } exp_t;

  exp_t exp_q[$];
  int   asserts = 0;
  int   fails = 0;

  int mon_idx = 0, mon_lat = 0, mon_sng = 0, mon_clr = 0, mon_str = 0;
  int mon_bad = 0, mon_tbad = 0, mon_ov = 0, mon_consume = 0;
  bit mon_armed = 1'b0, mon_done = 1'b0;

  sc_mac_sequencer #(
    .LEN_W (LEN_W),
    .TERM_W(TERM_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_terms(cmd_terms),
    .abort    (abort),
    .sng_load (sng_load),
    .stream_en(stream_en),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .term_idx (term_idx),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Monitor: index 0 is the cycle right after the accept edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon_armed <= 1'b0;
      mon_done  <= 1'b0;
    end else begin
      if (((!busy || out_valid) && (sng_load || stream_en || acc_clr || acc_en)) ||
          (cmd_ready === busy) || (stream_en !== acc_en))
        mon_bad <= mon_bad + 1;
      if (mon_armed && !mon_done) begin
        mon_idx <= mon_idx + 1;
        if (sng_load) begin
          mon_sng <= mon_sng + 1;
          if (int'(term_idx) != mon_sng) mon_tbad <= mon_tbad + 1;
        end else if (stream_en && (int'(term_idx) != mon_sng - 1)) begin
          mon_tbad <= mon_tbad + 1;
        end
        if (acc_clr) mon_clr <= mon_clr + 1;
        if (stream_en) mon_str <= mon_str + 1;
        if (out_valid) begin
          mon_done <= 1'b1;
          mon_lat  <= mon_idx + 1;
        end
      end
      if (out_valid) mon_ov <= mon_ov + 1;
      if (out_valid && out_ready && !abort) mon_consume <= mon_consume + 1;
      if (cmd_valid && cmd_ready) begin
        mon_armed <= 1'b1;
        mon_done  <= 1'b0;
        mon_idx   <= -1;
        mon_sng   <= 0;
        mon_clr   <= 0;
        mon_str   <= 0;
      end
    end
  end

  task automatic issue(input int l, input int k, input bit expect_done);
    int   n;
    exp_t e;
    int   le, ke;
    le = (l == 0) ? 256 : l;
    ke = (k == 0) ? 16 : k;
    if (expect_done) begin
      e.lat = ke * (le + 1);
      e.sng = ke;
      e.clr = 1;
      e.str = ke * le;
      exp_q.push_back(e);
    end
    cmd_len   = LEN_W'(l);
    cmd_terms = TERM_W'(k);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      asserts++;
      fails++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    asserts++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b need 1", cmd_ready); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b need 0", busy); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    asserts++; if ({sng_load, stream_en, acc_clr, acc_en} !== 4'b0) begin
      fails++; $display("FAIL rst_strobes: got %b need 0000", {sng_load, stream_en, acc_clr, acc_en}); end
    asserts++; if (term_idx !== '0) begin fails++; $display("FAIL rst_term_idx: got %0d need 0", term_idx); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    asserts++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_release: cmd_ready=%b busy=%b need 1/0", cmd_ready, busy); end
  endtask

  task automatic test_stream_shapes;
    int   tl[5] = '{4, 3, 0, 1, 7};
    int   tk[5] = '{1, 3, 1, 0, 2};
    bit   ok;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      issue(tl[i], tk[i], 1'b1);
      wait_valid(ok);
      asserts++; if (!ok) begin fails++; $display("FAIL shape%0d_timeout: out_valid=%b need 1", i, out_valid); end
      @(negedge clk); #1;
      e = exp_q.pop_front();
      $display("txn L=%0d K=%0d lat=%0d sng=%0d clr=%0d str=%0d", tl[i], tk[i], mon_lat, mon_sng, mon_clr, mon_str);
      asserts++; if (mon_lat != e.lat) begin fails++; $display("FAIL shape%0d_latency: got %0d need %0d", i, mon_lat, e.lat); end
      asserts++; if (mon_sng != e.sng) begin fails++; $display("FAIL shape%0d_sng_load: got %0d need %0d", i, mon_sng, e.sng); end
      asserts++; if (mon_clr != e.clr) begin fails++; $display("FAIL shape%0d_acc_clr: got %0d need %0d", i, mon_clr, e.clr); end
      asserts++; if (mon_str != e.str) begin fails++; $display("FAIL shape%0d_stream_en: got %0d need %0d", i, mon_str, e.str); end
      asserts++; if (mon_tbad != 0 || mon_bad != 0) begin
        fails++; $display("FAIL shape%0d_protocol: term errs %0d strobe errs %0d need 0/0", i, mon_tbad, mon_bad); end
      @(posedge clk); #1;
      asserts++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++; $display("FAIL shape%0d_idle: busy=%b cmd_ready=%b out_valid=%b need 0/1/0", i, busy, cmd_ready, out_valid); end
    end
  endtask

  task automatic test_abort;
    int n;
    int ov0;
    ov0 = mon_ov;
    issue(3, 3, 1'b0);
    n = 0;
    while (!(stream_en && term_idx == TERM_W'(1)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    asserts++; if (!(stream_en && term_idx == TERM_W'(1))) begin
      fails++; $display("FAIL abort_reach_term1: stream_en=%b term_idx=%0d need 1/1", stream_en, term_idx); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    asserts++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL abort_idle: busy=%b cmd_ready=%b need 0/1", busy, cmd_ready); end
    repeat (20) @(posedge clk);
    #1;
    $display("txn L=3 K=3 aborted in term 1");
    asserts++; if (mon_ov != ov0) begin fails++; $display("FAIL abort_no_valid: out_valid cycles %0d need 0", mon_ov - ov0); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    asserts++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_in_idle: cmd_ready=%b busy=%b need 1/0", cmd_ready, busy); end
  endtask

  task automatic test_done_hold;
    bit   ok;
    int   cons0;
    exp_t e;
    out_ready = 1'b0;
    issue(2, 1, 1'b1);
    wait_valid(ok);
    asserts++; if (!ok) begin fails++; $display("FAIL hold_timeout: out_valid=%b need 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_cycle%0d: out_valid=%b need 1", i, out_valid); end
    end
    e = exp_q.pop_front();
    asserts++; if (mon_lat != e.lat) begin fails++; $display("FAIL hold_latency: got %0d need %0d", mon_lat, e.lat); end
    cons0 = mon_consume;
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    $display("txn L=2 K=1 held 5 cycles then aborted in DONE");
    asserts++; if (busy !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL hold_abort_idle: busy=%b out_valid=%b cmd_ready=%b need 0/0/1", busy, out_valid, cmd_ready); end
    asserts++; if (mon_consume != cons0) begin fails++; $display("FAIL hold_no_consume: consumes %0d need 0", mon_consume - cons0); end
  endtask

  task automatic test_rst_mid;
    int   n;
    int   ov0;
    bit   ok;
    exp_t e;
    issue(5, 2, 1'b0);
    n = 0;
    while (!(stream_en && term_idx == TERM_W'(1)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    asserts++; if (!stream_en) begin fails++; $display("FAIL rstmid_reach_run: stream_en=%b need 1", stream_en); end
    rst = 1'b0;
    #1;
    asserts++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_flags: cmd_ready=%b busy=%b out_valid=%b need 1/0/0", cmd_ready, busy, out_valid); end
    asserts++; if ({sng_load, stream_en, acc_clr, acc_en} !== 4'b0 || term_idx !== '0) begin
      fails++; $display("FAIL rstmid_strobes: strobes=%b term_idx=%0d need 0000/0", {sng_load, stream_en, acc_clr, acc_en}, term_idx); end
    @(posedge clk); #1;
    rst = 1'b1;
    ov0 = mon_ov;
    repeat (10) @(posedge clk);
    #1;
    asserts++; if (mon_ov != ov0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_no_valid: out_valid cycles %0d busy=%b need 0/0", mon_ov - ov0, busy); end
    issue(2, 2, 1'b1);
    wait_valid(ok);
    asserts++; if (!ok) begin fails++; $display("FAIL rstmid_timeout: out_valid=%b need 1", out_valid); end
    @(negedge clk); #1;
    e = exp_q.pop_front();
    $display("txn L=2 K=2 after mid-run reset lat=%0d str=%0d", mon_lat, mon_str);
    asserts++; if (mon_lat != e.lat || mon_str != e.str) begin
      fails++; $display("FAIL rstmid_recover: lat=%0d str=%0d need %0d/%0d", mon_lat, mon_str, e.lat, e.str); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    issue(2, 2, 1'b1);
    wait_valid(ok);
    asserts++; if (!ok) begin fails++; $display("FAIL b2b_a_timeout: out_valid=%b need 1", out_valid); end
    @(negedge clk); #1;
    e = exp_q.pop_front();
    $display("txn b2b A L=2 K=2 lat=%0d", mon_lat);
    asserts++; if (mon_lat != e.lat || mon_sng != e.sng) begin
      fails++; $display("FAIL b2b_a: lat=%0d sng=%0d need %0d/%0d", mon_lat, mon_sng, e.lat, e.sng); end
    issue(5, 1, 1'b1);
    wait_valid(ok);
    asserts++; if (!ok) begin fails++; $display("FAIL b2b_b_timeout: out_valid=%b need 1", out_valid); end
    @(negedge clk); #1;
    e = exp_q.pop_front();
    $display("txn b2b B L=5 K=1 lat=%0d", mon_lat);
    asserts++; if (mon_lat != e.lat || mon_str != e.str || mon_clr != e.clr) begin
      fails++; $display("FAIL b2b_b: lat=%0d str=%0d clr=%0d need %0d/%0d/%0d", mon_lat, mon_str, mon_clr, e.lat, e.str, e.clr); end
    asserts++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d left need 0", exp_q.size()); end
    asserts++; if (mon_bad != 0 || mon_tbad != 0) begin
      fails++; $display("FAIL final_protocol: strobe errs %0d term errs %0d need 0/0", mon_bad, mon_tbad); end
  endtask

  initial begin
    test_reset();
    test_stream_shapes();
    test_abort();
    test_done_hold();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
